// File: rtl/gate_pkg.sv
// Shared operation encoding, queue state encoding and the bitwise operation helper
// used by the gate unit and its result queue.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_XNOR   = 3'd3,
        OP_NAND   = 3'd4,
        OP_NOR    = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } gate_op_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } fifo_state_t;

    localparam int OP_MAX_W = 64;

    // Operands are zero-extended to the widest legal width; callers truncate the result.
    function automatic logic [OP_MAX_W-1:0] apply_op(
        input gate_op_t              op,
        input logic [OP_MAX_W-1:0]   a,
        input logic [OP_MAX_W-1:0]   b
    );
        logic [OP_MAX_W-1:0] r;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_XNOR:   r = ~(a ^ b);
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_NOT_A:  r = ~a;
            OP_PASS_A: r = a;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_fifo2.sv
// Two-entry valid/ready result queue; the head entry is always held in head_q
// so the output never needs a read mux.
module gate_fifo2
    import gate_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    fifo_state_t   state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push, pop;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        in_ready  = (state_q != Q_TWO);
        out_valid = (state_q != Q_EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? head_q : '0;
        case (state_q)
            Q_EMPTY: begin
                if (push) begin
                    head_d  = in_data;
                    state_d = Q_ONE;
                end
            end
            Q_ONE: begin
                // With a simultaneous pop the new entry replaces the old head directly.
                case ({push, pop})
                    2'b10: begin
                        tail_d  = in_data;
                        state_d = Q_TWO;
                    end
                    2'b01:   state_d = Q_EMPTY;
                    2'b11:   head_d  = in_data;
                    default: state_d = Q_ONE;
                endcase
            end
            Q_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = Q_ONE;
                end
            end
            default: state_d = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= Q_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/bitwise_gate_unit.sv
// Bitwise gate unit: decodes op, computes result and equality at accept time,
// queues them in a two-entry FIFO and counts accepted operand matches.
module bitwise_gate_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             eq,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             ready_en_q, ready_en_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             fifo_in_ready;
    logic             accept;
    logic             eq_calc;
    logic [WIDTH-1:0] y_calc;
    logic [WIDTH:0]   fifo_out_data;

    assign eq_calc = &(a ~^ b);
    assign y_calc  = WIDTH'(apply_op(gate_op_t'(op), OP_MAX_W'(a), OP_MAX_W'(b)));

    // ready_en_q keeps in_ready low throughout reset and until the first edge after release.
    always_comb begin
        ready_en_d  = 1'b1;
        in_ready    = ready_en_q && fifo_in_ready;
        accept      = in_valid && in_ready;
        match_cnt_d = match_cnt_q;
        if (clr_cnt) begin
            match_cnt_d = '0;
        end else if (accept && eq_calc && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    gate_fifo2 #(
        .DW(WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid && ready_en_q),
        .in_ready (fifo_in_ready),
        .in_data  ({eq_calc, y_calc}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fifo_out_data)
    );

    assign y         = fifo_out_data[WIDTH-1:0];
    assign eq        = fifo_out_data[WIDTH];
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_bitwise_gate_unit.sv
// Scoreboard bench for bitwise_gate_unit: directed vectors push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_bitwise_gate_unit;
    import gate_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready, eq, clr_cnt;
    logic [7:0]  a, b, y;
    logic [2:0]  op;
    logic [15:0] match_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_eq, s_clr_cnt;
    logic        s_out_ready = 1'b1;
    logic [7:0]  s_a, s_b, s_y;
    logic [2:0]  s_op;
    logic [1:0]  s_match_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] y;
        logic       eq;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bitwise_gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .eq(eq), .clr_cnt(clr_cnt), .match_cnt(match_cnt)
    );

    bitwise_gate_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .y(s_y), .eq(s_eq), .clr_cnt(s_clr_cnt), .match_cnt(s_match_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Offer one transaction (called at posedge+1); push the expected entry once in_ready is seen.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] ey, input logic ee, input bit lat);
        int   waitc;
        exp_t e;
        waitc = 0;
        op = o;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
        end else begin
            e.y = ey;
            e.eq = ee;
            e.cyc = lat ? cyc + 1 : -1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got y=%0h, required no output", y);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("y", y, mon_e.y);
                checkOutput("eq", eq, mon_e.eq);
                if (mon_e.cyc >= 0) checkOutput("latency_cycle", cyc, mon_e.cyc);
            end
        end else if (!out_valid) begin
            checkOutput("idle_y", y, 0);
            checkOutput("idle_eq", eq, 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    logic [7:0] t1_y [8] = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        in_valid = 0; a = 0; b = 0; op = 0; out_ready = 1; clr_cnt = 0;
        s_in_valid = 0; s_a = 0; s_b = 0; s_op = 0; s_clr_cnt = 0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_match_cnt", match_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_first_edge", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_first_edge", in_ready, 1);

        $display("[TB] all ops, a=A5 b=0F");
        for (int i = 0; i < 8; i++) applyStimulus(3'(i), 8'hA5, 8'h0F, t1_y[i], 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] backpressure with three offers");
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
                applyStimulus(OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0);
                applyStimulus(OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checkOutput("ready_full", in_ready, 0);
                checkOutput("valid_full", out_valid, 1);
                checkOutput("held_y", y, 8'h30);
                @(negedge clk);
                checkOutput("held_y_again", y, 8'h30);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        checkOutput("ready_after_drain", in_ready, 1);
        checkOutput("valid_after_drain", out_valid, 0);

        $display("[TB] equality and match counter");
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(OP_AND, 8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b1);
        applyStimulus(OP_XOR, 8'h3C, 8'h3D, 8'h01, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("match_cnt_3", match_cnt, 3);

        $display("[TB] push and pop together in ONE");
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 11; i++) applyStimulus(OP_PASS_A, 8'(i), 8'hFF, 8'(i), 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    checkOutput("stream_valid", out_valid, 1);
                    checkOutput("stream_not_two", in_ready, 1);
                end
            end
        join
        checkOutput("match_cnt_after_stream", match_cnt, 3);

        $display("[TB] saturating counter, CNT_W=2");
        s_a = 8'h11; s_b = 8'h11; s_op = OP_AND; s_in_valid = 1'b1;
        checkOutput("sat_ready", s_in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("sat_cnt", s_match_cnt, sat_exp[i]);
        end
        checkOutput("sat_valid", s_out_valid, 1);
        checkOutput("sat_y", s_y, 8'h11);
        checkOutput("sat_eq", s_eq, 1);
        s_clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sat_clr_with_match", s_match_cnt, 0);
        s_clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("sat_count_after_clr", s_match_cnt, 1);
        s_in_valid = 1'b0;

        $display("[TB] reset with queue full");
        out_ready = 1'b0;
        applyStimulus(OP_OR,   8'h12, 8'h34, 8'h36, 1'b0, 1'b0);
        applyStimulus(OP_NAND, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("two_before_reset", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_y", y, 0);
        checkOutput("reset_eq", eq, 0);
        checkOutput("reset_match_cnt", match_cnt, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("release_ready_after_edge", in_ready, 1);
        checkOutput("release_out_valid", out_valid, 0);
        applyStimulus(OP_XNOR, 8'hF0, 8'hF0, 8'hFF, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("match_cnt_after_reset", match_cnt, 1);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitwise_gate_unit.md
BITWISE_GATE_UNIT -- requirements
Module: bitwise_gate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 16: match-counter width in bits, legal range 1..32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand transaction offered.
REQ-006 SHALL have port in_ready  output  1  unit can accept a transaction this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  3  gate_op_t selecting the bitwise operation.
REQ-010 SHALL have port out_valid  output  1  result at head of queue is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port y  output  WIDTH  result of head entry.
REQ-013 SHALL have port eq  output  1  head entry had a==b, i.e. AND-reduction of bitwise XNOR.
REQ-014 SHALL have port clr_cnt  input  1  synchronous clear of match_cnt.
REQ-015 SHALL have port match_cnt  output  CNT_W  count of accepted transactions with a==b.

Function
REQ-016 SHALL decode op: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT_A (~a), 7 PASS_A (a); every op is bitwise across all WIDTH bits.
REQ-017 SHALL accept a transaction on a clk edge where in_valid=1 and in_ready=1; op, a and b are sampled only on that edge.
REQ-018 SHALL compute y and eq at accept time and store them together as one entry in a 2-entry queue.
REQ-019 SHALL assert out_valid on the cycle after accept into an empty queue, giving 1-cycle latency.
REQ-020 SHALL pop the head entry on a clk edge where out_valid=1 and out_ready=1.
REQ-021 SHALL implement queue states EMPTY, ONE and TWO: push only EMPTY->ONE; push only ONE->TWO; pop only TWO->ONE; pop only ONE->EMPTY; push and pop together in ONE stays ONE, and the new entry becomes the head.
REQ-022 SHALL drive in_ready=1 in EMPTY and ONE, and in_ready=0 in TWO, so a push in TWO cannot occur.
REQ-023 SHALL sustain one transaction per cycle when out_ready is held at 1.
REQ-024 SHALL hold y and eq stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive y=0 and eq=0 whenever out_valid=0.
REQ-026 SHALL preserve queue order: results emerge in accept order with none dropped or duplicated.
REQ-027 SHALL increment match_cnt by 1 on each accepted transaction with a==b, irrespective of op.
REQ-028 SHALL saturate match_cnt at 2^CNT_W-1.
REQ-029 SHALL set match_cnt to 0 on any edge with clr_cnt=1, including when a matching accept occurs on the same edge.
REQ-030 SHALL NOT let in_valid/a/b/op changes without an accept alter any state.

Reset
REQ-031 SHALL, while rst_n=0, immediately force queue EMPTY, out_valid=0, y=0, eq=0, match_cnt=0 and in_ready=0.
REQ-032 SHALL discard all queued entries on reset assertion mid-operation.
REQ-033 SHALL drive in_ready=1 from the first clk edge after rst_n deasserts.

Structure
REQ-034 SHALL take gate_op_t (3-bit enum) and the function apply_op(op,a,b) from shared package gate_pkg.
REQ-035 SHALL place the 2-entry queue, WIDTH+1 bits per entry, in sub-module gate_fifo2 with its own valid/ready ports.
REQ-036 SHALL keep the match counter and op decode in bitwise_gate_unit.

Verification
REQ-037 SHALL cover: WIDTH=8, out_ready=1, ops 0..7 with a=8'hA5, b=8'h0F -> y = 05, AF, AA, 55, FA, 50, 5A, A5 on consecutive cycles, each 1 cycle after accept.
REQ-038 SHALL cover: out_ready=0, 3 offers -> in_ready drops after 2 accepts; release out_ready -> results in order, then in_ready=1.
REQ-039 SHALL cover: a=b=8'h3C on 3 accepts plus a=8'h3C, b=8'h3D on 1 accept -> eq pattern 1,1,1,0 and match_cnt=3.
REQ-040 SHALL cover: CNT_W=2, 5 matching accepts -> match_cnt=3 (saturated); clr_cnt with a matching accept on the same edge -> match_cnt=0.
REQ-041 SHALL cover: rst_n pulsed low with queue in TWO -> out_valid=0, y=0, match_cnt=0 immediately; in_ready=1 on the first edge after release.
REQ-042 SHALL cover: queue in ONE with push and pop on the same edge for 10 cycles -> out_valid stays 1 and the queue never reaches TWO.
